multicycle_sub: RTL and testbench
=================================

# multicycle_sub

- Parametrised, digit-serial subtractor: computes `y = a - b - bin` on `WIDTH`-bit operands, `DIGIT` bits per clock, LSB digit first.
- The borrow is registered between digits.
- Valid/ready handshakes on input and output, with zero and signed-overflow flags.
- Sits between operand registers and the ALU result bus, where a full-width ripple chain would not close timing.

## Interface

Parameters:
- `WIDTH`, 32, operand/result width in bits.
- `DIGIT`, 8, bits processed per cycle.
  - Must satisfy 1 ≤ `DIGIT` ≤ `WIDTH` and `WIDTH % DIGIT == 0`.
  - Violation is an elaboration-time error.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `in_valid` in 1: operands presented.
- `in_ready` out 1: block can accept operands this cycle.
- `a` in `WIDTH`: minuend.
- `b` in `WIDTH`: subtrahend.
- `bin` in 1: borrow-in.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `y` out `WIDTH`: difference, modulo 2^`WIDTH`.
- `bout` out 1: borrow-out, 1 iff unsigned `a < b + bin`.
- `zero` out 1: `y == 0`.
- `ovf` out 1: signed overflow.

## Operation

- `ND = WIDTH / DIGIT` digit steps per operation.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: `in_ready = 1`. On `in_valid`, capture `a`, `b`, `bin`, clear digit counter, go to BUSY.
  - BUSY: each cycle, subtract digit k of the captured operands with the registered borrow. Write the digit into `y[k*DIGIT +: DIGIT]` and register the borrow out. After digit `ND-1`, go to DONE.
  - DONE: `out_valid = 1`; `y`/`bout`/`zero`/`ovf` held stable.
    - `out_ready = 0`: stay in DONE.
    - `out_ready = 1` and `in_valid = 0`: go to IDLE.
    - `out_ready = 1` and `in_valid = 1`: capture the new operands and go directly to BUSY.
- `in_ready = (state == IDLE) || (state == DONE && out_ready)`. This is combinational from `out_ready`; that path is permitted.
- Operands are captured only at acceptance. Changes on `a`/`b`/`bin` during BUSY/DONE have no effect.
- Digit 0 uses the captured `bin` as borrow-in. `bout` is the borrow-out of digit `ND-1`.
- Flags are computed when the last digit is written, i.e. registered on entry to DONE:
  - `ovf` = borrow-into-MSB XOR borrow-out-of-MSB.
  - `zero` = `y == 0` over the full word.
- The `y` register is cleared at acceptance, so partial results never show stale upper digits.

## Timing

- Acceptance at edge E0 (`in_valid && in_ready`).
- Digits are computed on edges E1..E`ND`.
- `out_valid` rises after edge E`ND`, giving a latency of `ND` cycles from acceptance.
- Maximum throughput: one operation per `ND+1` cycles (DONE lasts at least 1 cycle).
- `DIGIT == WIDTH`: `ND = 1`, so result at E1.
- Reset values (async, immediate on `rst` assertion):
  - state IDLE, `in_ready = 1`.
  - `out_valid = 0`.
  - `y = 0`, `bout = 0`, `zero = 0`, `ovf = 0`.
  - Digit counter and operand registers 0.
- Reset mid-operation aborts the operation; no result is produced. The first acceptance is possible on the first edge after `rst` deasserts.
- Critical path: one `DIGIT`-bit ripple borrow chain plus the counter-indexed operand mux.

## Structure

- Package `sub_pkg`:
  - state enum (`IDLE`, `BUSY`, `DONE`).
  - `ND` computation function.
  - counter width `$clog2(ND)` with a minimum of 1.
- Sub-module `sub_slice #(DIGIT)`:
  - Generate-loop chain of `DIGIT` existing `full_sub` cells.
  - Ports: `a`, `b`, `bi`, `y`, `bo`, and `b_msb_in` (borrow into its top bit, used for `ovf`).
- Top level holds the FSM, digit counter, operand/result registers and flag logic.
- One `sub_slice` instance, time-multiplexed across digits.

## Test plan

All scenarios use `WIDTH = 16`, `DIGIT = 4`, so `ND = 4`.

1. Accept `a=0x1234`, `b=0x0034`, `bin=0` → after 4 cycles `out_valid = 1`, `y=0x1200`, `bout=0`, `zero=0`, `ovf=0`.
2. Underflow and overflow cases:
   - `0x0000 - 0x0001` → `y=0xFFFF`, `bout=1`, `ovf=0`.
   - `0x8000 - 0x0001` → `y=0x7FFF`, `bout=0`, `ovf=1`.
   - `0x7FFF - 0xFFFF` → `y=0x8000`, `bout=1`, `ovf=1`.
3. `0x0005 - 0x0004` with `bin=1` → `y=0x0000`, `zero=1`, `bout=0`. Borrow ripples across all digits: `0x1000 - 0x0001` → `y=0x0FFF`.
4. Backpressure:
   - Hold `out_ready=0` for 3 cycles in DONE → `y`/flags stable, `in_ready=0`.
   - Then assert `out_ready=1` and `in_valid=1` in the same cycle → new op accepted, next `out_valid` exactly 4 cycles later.
5. Operand change during BUSY → result matches the captured operands.
6. Assert `rst` during digit 2 → all outputs 0 and `in_ready=1` immediately; a new op after release completes correctly.
7. Re-elaborate with `DIGIT=16` → latency 1; `DIGIT=5` fails elaboration.

Source files
------------

// File: rtl/sub_pkg.sv
// sub_pkg: shared FSM states and digit-count helpers for the digit-serial subtractor
package sub_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic int nd(input int w, input int d);
    return (d > 0) ? w / d : 1;
  endfunction
  function automatic int cnt_w(input int w, input int d);
    return (nd(w, d) > 1) ? $clog2(nd(w, d)) : 1;
  endfunction
endpackage

// File: rtl/full_sub.sv
// full_sub: one-bit full subtractor cell
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

// File: rtl/sub_slice.sv
// sub_slice: DIGIT-bit ripple-borrow subtractor built from full_sub cells
module sub_slice #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bi,
  output logic [DIGIT-1:0] y,
  output logic             bo,
  output logic             b_msb_in
);
  logic [DIGIT:0] br;
  assign br[0]    = bi;
  assign bo       = br[DIGIT];
  assign b_msb_in = br[DIGIT-1];
  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    full_sub u_fs (.a(a[i]), .b(b[i]), .bi(br[i]), .d(y[i]), .bo(br[i+1]));
  end
endmodule

// File: rtl/multicycle_sub.sv
// multicycle_sub: digit-serial a - b - bin with valid/ready handshakes and zero/overflow flags
module multicycle_sub
  import sub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);
  localparam int NDIG = nd(WIDTH, DIGIT);
  localparam int CW   = cnt_w(WIDTH, DIGIT);
  if (DIGIT < 1 || DIGIT > WIDTH || WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("multicycle_sub: DIGIT must be in 1..WIDTH and divide WIDTH");
  end
  state_t          state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, y_q, y_d;
  logic             brw_q, brw_d, bout_q, bout_d, zero_q, zero_d, ovf_q, ovf_d;
  logic [DIGIT-1:0] s_y;
  logic             s_bo, s_bm, accept, last;
  assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt_q == CW'(NDIG - 1));
  assign y    = y_q;
  assign bout = bout_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;
  sub_slice #(.DIGIT(DIGIT)) u_slice (
    .a(a_q[cnt_q*DIGIT +: DIGIT]),
    .b(b_q[cnt_q*DIGIT +: DIGIT]),
    .bi(brw_q),
    .y(s_y),
    .bo(s_bo),
    .b_msb_in(s_bm)
  );
  // next state: write one digit per BUSY cycle, flags on the last digit, capture on acceptance
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    y_d     = y_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    if (state_q == BUSY) begin
      y_d[cnt_q*DIGIT +: DIGIT] = s_y;
      brw_d = s_bo;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        state_d = DONE;
        cnt_d   = '0;
        bout_d  = s_bo;
        ovf_d   = s_bm ^ s_bo;
        zero_d  = ~|y_d;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
    if (accept) begin
      state_d = BUSY;
      cnt_d   = '0;
      a_d     = a;
      b_d     = b;
      brw_d   = bin;
      y_d     = '0;
      bout_d  = 1'b0;
      zero_d  = 1'b0;
      ovf_d   = 1'b0;
    end
  end
  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      y_q     <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      brw_q   <= brw_d;
      y_q     <= y_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_multicycle_sub.sv
// tb_multicycle_sub: directed checks of the digit-serial subtractor
module tb_multicycle_sub;
  logic        clk = 0, rst = 1;
  logic        in_valid = 0, out_ready = 0, in_valid2 = 0, out_ready2 = 0;
  logic [15:0] a = 0, b = 0;
  logic        bin = 0;
  logic        in_ready, out_valid, bout, zero, ovf;
  logic        in_ready2, out_valid2, bout2, zero2, ovf2;
  logic [15:0] y, y2;
  int          tests = 0, fails = 0;

  multicycle_sub #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .bout(bout), .zero(zero), .ovf(ovf));
  multicycle_sub #(.WIDTH(16), .DIGIT(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .a(a), .b(b), .bin(bin),
    .out_valid(out_valid2), .out_ready(out_ready2), .y(y2), .bout(bout2), .zero(zero2), .ovf(ovf2));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic do_op(input logic [15:0] ia, ib, input logic ibin,
                       output logic [15:0] oy, output logic obo, oz, oov, output int lat);
    a = ia; b = ib; bin = ibin; in_valid = 1;
    tick();
    in_valid = 0;
    wait_done(lat);
    oy = y; obo = bout; oz = zero; oov = ovf;
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({in_ready, out_valid, y, bout, zero, ovf} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
      fails++;
      $display("FAIL reset got rdy=%b vld=%b y=%h bo=%b z=%b o=%b", in_ready, out_valid, y, bout, zero, ovf);
    end
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_basic();
    logic [15:0] oy; logic obo, oz, oov; int lat;
    do_op(16'h1234, 16'h0034, 0, oy, obo, oz, oov, lat);
    tests++;
    if (lat !== 4) begin fails++; $display("FAIL basic_latency got %0d exp 4", lat); end
    tests++;
    if ({oy, obo, oz, oov} !== {16'h1200, 3'b000}) begin
      fails++; $display("FAIL basic got y=%h bo=%b z=%b o=%b exp y=1200 000", oy, obo, oz, oov);
    end
  endtask

  task automatic test_flags();
    logic [15:0] oy; logic obo, oz, oov; int lat;
    do_op(16'h0000, 16'h0001, 0, oy, obo, oz, oov, lat);
    tests++;
    if ({oy, obo, oz, oov} !== {16'hFFFF, 3'b100}) begin
      fails++; $display("FAIL under got y=%h bo=%b z=%b o=%b exp y=ffff 100", oy, obo, oz, oov);
    end
    do_op(16'h8000, 16'h0001, 0, oy, obo, oz, oov, lat);
    tests++;
    if ({oy, obo, oz, oov} !== {16'h7FFF, 3'b001}) begin
      fails++; $display("FAIL ovf_neg got y=%h bo=%b z=%b o=%b exp y=7fff 001", oy, obo, oz, oov);
    end
    do_op(16'h7FFF, 16'hFFFF, 0, oy, obo, oz, oov, lat);
    tests++;
    if ({oy, obo, oz, oov} !== {16'h8000, 3'b101}) begin
      fails++; $display("FAIL ovf_pos got y=%h bo=%b z=%b o=%b exp y=8000 101", oy, obo, oz, oov);
    end
  endtask

  task automatic test_zero_ripple();
    logic [15:0] oy; logic obo, oz, oov; int lat;
    do_op(16'h0005, 16'h0004, 1, oy, obo, oz, oov, lat);
    tests++;
    if ({oy, obo, oz, oov} !== {16'h0000, 3'b010}) begin
      fails++; $display("FAIL zero got y=%h bo=%b z=%b o=%b exp y=0000 010", oy, obo, oz, oov);
    end
    do_op(16'h1000, 16'h0001, 0, oy, obo, oz, oov, lat);
    tests++;
    if ({oy, obo, oz, oov} !== {16'h0FFF, 3'b000}) begin
      fails++; $display("FAIL ripple got y=%h bo=%b z=%b o=%b exp y=0fff 000", oy, obo, oz, oov);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    a = 16'h00F0; b = 16'h000F; bin = 0; in_valid = 1;
    tick();
    a = 16'h0003; b = 16'h0005;
    wait_done(lat);
    tests++;
    if (lat !== 4) begin fails++; $display("FAIL bp_latency got %0d exp 4", lat); end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({out_valid, in_ready, y, bout, zero, ovf} !== {2'b10, 16'h00E1, 3'b000}) begin
        fails++; $display("FAIL bp_hold%0d got vld=%b rdy=%b y=%h bo=%b z=%b o=%b exp 1 0 00e1 000",
                          i, out_valid, in_ready, y, bout, zero, ovf);
      end
      tick();
    end
    out_ready = 1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready got %b exp 1", in_ready); end
    tick();
    out_ready = 0; in_valid = 0;
    wait_done(lat);
    tests++;
    if (lat !== 4) begin fails++; $display("FAIL b2b_latency got %0d exp 4", lat); end
    tests++;
    if ({y, bout, zero, ovf} !== {16'hFFFE, 3'b100}) begin
      fails++; $display("FAIL b2b got y=%h bo=%b z=%b o=%b exp y=fffe 100", y, bout, zero, ovf);
    end
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  task automatic test_operand_change();
    int lat;
    a = 16'h4321; b = 16'h1111; bin = 0; in_valid = 1;
    tick();
    in_valid = 0; a = 16'hFFFF; b = 16'h0000; bin = 1;
    tick();
    a = 16'h0000; b = 16'hFFFF;
    wait_done(lat);
    tests++;
    if ({y, bout, zero, ovf} !== {16'h3210, 3'b000}) begin
      fails++; $display("FAIL capture got y=%h bo=%b z=%b o=%b exp y=3210 000", y, bout, zero, ovf);
    end
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  task automatic test_mid_reset();
    logic [15:0] oy; logic obo, oz, oov; int lat;
    a = 16'hFFFF; b = 16'h1111; bin = 0; in_valid = 1;
    tick();
    in_valid = 0;
    tick(); tick();
    rst = 1;
    #1;
    tests++;
    if ({in_ready, out_valid, y, bout, zero, ovf} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
      fails++; $display("FAIL mid_reset got rdy=%b vld=%b y=%h bo=%b z=%b o=%b", in_ready, out_valid, y, bout, zero, ovf);
    end
    tick();
    rst = 0;
    tick();
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL abort got vld=%b exp 0", out_valid); end
    do_op(16'h0100, 16'h0001, 0, oy, obo, oz, oov, lat);
    tests++;
    if ({oy, obo, oz, oov, lat} !== {16'h00FF, 3'b000, 32'd4}) begin
      fails++; $display("FAIL post_reset got y=%h bo=%b z=%b o=%b lat=%0d exp y=00ff 000 4", oy, obo, oz, oov, lat);
    end
  endtask

  task automatic test_full_digit();
    int lat = 0;
    a = 16'h8000; b = 16'h0001; bin = 0; in_valid2 = 1;
    tick();
    in_valid2 = 0;
    while (!out_valid2 && lat < 20) begin
      tick();
      lat++;
    end
    tests++;
    if ({lat, y2, bout2, zero2, ovf2} !== {32'd1, 16'h7FFF, 3'b001}) begin
      fails++; $display("FAIL digit16 got lat=%0d y=%h bo=%b z=%b o=%b exp 1 7fff 001", lat, y2, bout2, zero2, ovf2);
    end
    out_ready2 = 1;
    tick();
    out_ready2 = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flags();
    test_zero_ripple();
    test_back_to_back();
    test_operand_change();
    test_mid_reset();
    test_full_digit();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
